// File: rtl/branch_predictor.sv
// branch_predictor: 4-entry 2-bit saturating-counter branch predictor with MEM-stage resolution
// Optional feature: define BP_STATS_EN to add the STATlookups/STATmiss statistics counters.
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   IFpc, IFen                     fetch PC, fetch-advance strobe (statistics only)
//   PRbpc, PRtag, PRvalid          target-buffer entry selected by IFpcindex
//   IFpcindex, IFnpc, IFtaken      buffer index, predicted next PC, predict-taken flag
//   MMbranch, MMtaken, MMpc,
//   MMtarget, MMprednpc            resolved branch in MEM and the prediction carried with it
//   MMmispredict, MMfixpc          flush request and corrected fetch PC
//   STATlookups, STATmiss          saturating hit-lookup and mispredict counts (BP_STATS_EN)
module branch_predictor (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] IFpc,
   input  logic        IFen,
   input  logic [31:0] PRbpc,
   input  logic [27:0] PRtag,
   input  logic        PRvalid,
   output logic [1:0]  IFpcindex,
   output logic [31:0] IFnpc,
   output logic        IFtaken,
   input  logic        MMbranch,
   input  logic        MMtaken,
   input  logic [31:0] MMpc,
   input  logic [31:0] MMtarget,
   input  logic [31:0] MMprednpc,
   output logic        MMmispredict,
   output logic [31:0] MMfixpc
`ifdef BP_STATS_EN
   ,
   output logic [15:0] STATlookups,
   output logic [15:0] STATmiss
`endif
);
   logic [1:0] cnt [4];
   logic       hit;
   logic [1:0] cur;
   assign IFpcindex    = IFpc[3:2];
   assign hit          = PRvalid && (PRtag == IFpc[31:4]);
   assign IFtaken      = hit && cnt[IFpc[3:2]][1];
   assign IFnpc        = IFtaken ? PRbpc : IFpc + 32'd4;
   assign MMfixpc      = MMtaken ? MMtarget : MMpc + 32'd4;
   assign MMmispredict = MMbranch && (MMprednpc != MMfixpc);
   assign cur          = cnt[MMpc[3:2]];
   // IF reads the pre-edge counter, so a same-cycle update at the same index shows up next cycle
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST)
         for (int i = 0; i < 4; i++) cnt[i] <= 2'b01;
      else if (MMbranch)
         cnt[MMpc[3:2]] <= MMtaken ? (cur == 2'b11 ? cur : cur + 2'b01)
                                   : (cur == 2'b00 ? cur : cur - 2'b01);
`ifdef BP_STATS_EN
   always_ff @(posedge CLK or negedge nRST)
      if (!nRST) begin
         STATlookups <= 16'd0;
         STATmiss    <= 16'd0;
      end else begin
         STATlookups <= STATlookups + {15'd0, IFen && hit && STATlookups != 16'hFFFF};
         STATmiss    <= STATmiss + {15'd0, MMmispredict && STATmiss != 16'hFFFF};
      end
`else
   logic unused_ifen;
   assign unused_ifen = IFen;
`endif
endmodule
